// File: rtl/dec2bin_pkg.sv
// Shared widths, error classification and parameter sanity helpers for the
// one-hot to binary encoder.
package dec2bin_pkg;

  localparam int DEC_W_DEF   = 10;
  localparam int BIN_W_DEF   = 4;
  localparam int ERR_CNT_W   = 8;
  localparam int ERR_CNT_MAX = 255;

  typedef enum logic [1:0] {
    ERR_NONE_OK = 2'd0,
    ERR_ZERO    = 2'd1,
    ERR_MULTI   = 2'd2
  } err_kind_e;

  // Smallest code width able to index `lines` inputs.
  function automatic int min_code_w(input int lines);
    int w;
    w = 0;
    while ((1 << w) < lines) w++;
    return w;
  endfunction

  function automatic bit widths_ok(input int dec_w, input int bin_w);
    return (dec_w >= 2) && (dec_w <= 16) && (bin_w >= min_code_w(dec_w));
  endfunction

endpackage

// File: rtl/decimal_to_binary_encoder_onehot_prio_enc.sv
// Combinational priority encoder with zero / multi-hot detection; zero latency.
// The index and the error class are formed in parallel from the same input.
module onehot_prio_enc
  import dec2bin_pkg::*;
#(
  parameter int DEC_W     = DEC_W_DEF,
  parameter int BIN_W     = BIN_W_DEF,
  parameter int PRIO_HIGH = 1
) (
  input  logic [DEC_W-1:0] dec,
  output logic [BIN_W-1:0] idx,
  output err_kind_e        kind
);

  logic is_zero;
  logic is_multi;

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign is_zero  = ~|dec;
  assign is_multi = |(dec & (dec - DEC_W'(1)));

  if (PRIO_HIGH != 0) begin : g_high
    always_comb begin
      idx = '0;
      for (int i = 0; i < DEC_W; i++) begin
        if (dec[i]) idx = BIN_W'(i);
      end
    end
  end else begin : g_low
    always_comb begin
      idx = '0;
      for (int i = DEC_W - 1; i >= 0; i--) begin
        if (dec[i]) idx = BIN_W'(i);
      end
    end
  end

  always_comb begin
    kind = ERR_NONE_OK;
    if (is_zero)       kind = ERR_ZERO;
    else if (is_multi) kind = ERR_MULTI;
  end

endmodule

// File: rtl/decimal_to_binary_encoder.sv
// Registered one-hot to binary encoder, 1-cycle latency, accepts a new input every cycle (no backpressure).
// Optional saturating error counter with clear when DEC2BIN_ERR_CNT_EN is defined.
module decimal_to_binary_encoder
  import dec2bin_pkg::*;
#(
  parameter int DEC_W     = DEC_W_DEF,
  parameter int BIN_W     = BIN_W_DEF,
  parameter int PRIO_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEC_W-1:0] dec_in,
  input  logic             in_valid,
  output logic [BIN_W-1:0] bin_out,
  output logic             out_valid,
  output logic             err_none,
  output logic             err_multi
`ifdef DEC2BIN_ERR_CNT_EN
  ,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  if (!widths_ok(DEC_W, BIN_W) || (PRIO_HIGH < 0) || (PRIO_HIGH > 1)) begin : g_bad_params
    $fatal(1, "decimal_to_binary_encoder: illegal DEC_W/BIN_W/PRIO_HIGH");
  end

  logic [BIN_W-1:0] enc_idx;
  err_kind_e        enc_kind;

  onehot_prio_enc #(
    .DEC_W    (DEC_W),
    .BIN_W    (BIN_W),
    .PRIO_HIGH(PRIO_HIGH)
  ) u_enc (
    .dec (dec_in),
    .idx (enc_idx),
    .kind(enc_kind)
  );

  // Code and flags hold while idle; only out_valid tracks in_valid every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out   <= '0;
      out_valid <= 1'b0;
      err_none  <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        bin_out   <= enc_idx;
        err_none  <= (enc_kind == ERR_ZERO);
        err_multi <= (enc_kind == ERR_MULTI);
      end
    end
  end

`ifdef DEC2BIN_ERR_CNT_EN
  logic err_hit;

  assign err_hit = in_valid && (enc_kind != ERR_NONE_OK);

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= '0;
    end else if (err_hit && (err_cnt != ERR_CNT_W'(ERR_CNT_MAX))) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_decimal_to_binary_encoder.sv
// Scoreboard bench: high- and low-priority encoders driven in lockstep.
module tb_decimal_to_binary_encoder;
  import dec2bin_pkg::*;

  localparam int DEC_W = 10;
  localparam int BIN_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [DEC_W-1:0] dec_in;
  logic [BIN_W-1:0] bin_hi, bin_lo;
  logic             ov_hi, ov_lo, en_hi, en_lo, em_hi, em_lo;
`ifdef DEC2BIN_ERR_CNT_EN
  logic             err_clr;
  logic [7:0]       cnt_hi, cnt_lo;
`endif

  typedef struct packed {
    logic [BIN_W-1:0] bin_hi;
    logic [BIN_W-1:0] bin_lo;
    logic             none;
    logic             multi;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_checks = 0;
  int   n_pass   = 0;

  decimal_to_binary_encoder #(.DEC_W(DEC_W), .BIN_W(BIN_W), .PRIO_HIGH(1)) u_hi (
    .clk(clk), .rst(rst), .dec_in(dec_in), .in_valid(in_valid),
    .bin_out(bin_hi), .out_valid(ov_hi), .err_none(en_hi), .err_multi(em_hi)
`ifdef DEC2BIN_ERR_CNT_EN
    , .err_clr(err_clr), .err_cnt(cnt_hi)
`endif
  );

  decimal_to_binary_encoder #(.DEC_W(DEC_W), .BIN_W(BIN_W), .PRIO_HIGH(0)) u_lo (
    .clk(clk), .rst(rst), .dec_in(dec_in), .in_valid(in_valid),
    .bin_out(bin_lo), .out_valid(ov_lo), .err_none(en_lo), .err_multi(em_lo)
`ifdef DEC2BIN_ERR_CNT_EN
    , .err_clr(err_clr), .err_cnt(cnt_lo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [DEC_W-1:0] d);
    exp_t e;
    e.bin_hi = '0;
    e.bin_lo = '0;
    e.none   = (d == '0);
    e.multi  = ($countones(d) > 1);
    for (int i = 0; i < DEC_W; i++) if (d[i]) e.bin_hi = BIN_W'(i);
    for (int i = DEC_W - 1; i >= 0; i--) if (d[i]) e.bin_lo = BIN_W'(i);
    return e;
  endfunction

  task automatic drive(input logic [DEC_W-1:0] d, input logic v);
    dec_in   = d;
    in_valid = v;
    if (v && !rst) sb.push_back(model(d));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive('0, 1'b0);
    tick;
    tick;
    n_checks++;
    if ({bin_hi, bin_lo, ov_hi, ov_lo, en_hi, en_lo, em_hi, em_lo} !== '0)
      $display("FAIL reset_state: got bin=%h/%h ov=%b%b none=%b%b multi=%b%b want all 0",
               bin_hi, bin_lo, ov_hi, ov_lo, en_hi, en_lo, em_hi, em_lo);
    else n_pass++;
    rst  = 1'b0;
    last = '0;
  endtask

  task automatic test_walking_one;
    exp_t e;
    for (int i = 0; i < DEC_W; i++) begin
      drive(DEC_W'(1) << i, 1'b1);
      tick;
      n_checks++;
      if (ov_hi !== 1'b1 || ov_lo !== 1'b1 || sb.size() == 0) begin
        $display("FAIL walk%0d_valid: got out_valid=%b/%b want 1", i, ov_hi, ov_lo);
      end else begin
        e = sb.pop_front();
        last = e;
        if ({bin_hi, bin_lo, en_hi, em_hi, en_lo, em_lo} !== {e, e.none, e.multi})
          $display("FAIL walk%0d: got bin=%0d/%0d none=%b%b multi=%b%b want bin=%0d none=%b multi=%b",
                   i, bin_hi, bin_lo, en_hi, en_lo, em_hi, em_lo, e.bin_hi, e.none, e.multi);
        else if (bin_hi !== BIN_W'(i))
          $display("FAIL walk%0d_index: got %0d want %0d", i, bin_hi, i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_then_reset;
    exp_t             e;
    logic [DEC_W:0]   wide;
    logic [DEC_W-1:0] vec[2];
    wide   = 1 << DEC_W;
    vec[0] = '0;
    vec[1] = wide[DEC_W-1:0];
    for (int k = 0; k < 2; k++) begin
      drive(vec[k], 1'b1);
      tick;
      n_checks++;
      if (ov_hi !== 1'b1 || sb.size() == 0) begin
        $display("FAIL zero%0d_valid: got out_valid=%b want 1", k, ov_hi);
      end else begin
        e = sb.pop_front();
        last = e;
        if (bin_hi !== 4'd0 || bin_lo !== 4'd0 || en_hi !== 1'b1 || en_lo !== 1'b1 ||
            em_hi !== 1'b0 || em_lo !== 1'b0 || e.none !== 1'b1)
          $display("FAIL zero%0d: got bin=%0d/%0d none=%b%b multi=%b%b want bin=0 none=1 multi=0",
                   k, bin_hi, bin_lo, en_hi, en_lo, em_hi, em_lo);
        else n_pass++;
      end
    end
    drive(10'd64, 1'b1);
    tick;
    sb.delete();
    rst = 1'b1;
    drive(10'd4, 1'b1);
    tick;
    n_checks++;
    if ({bin_hi, bin_lo, ov_hi, ov_lo, en_hi, en_lo, em_hi, em_lo} !== '0)
      $display("FAIL reset_midstream: got bin=%h/%h ov=%b%b none=%b%b multi=%b%b want all 0",
               bin_hi, bin_lo, ov_hi, ov_lo, en_hi, en_lo, em_hi, em_lo);
    else n_pass++;
    rst  = 1'b0;
    last = '0;
  endtask

  task automatic test_multi_then_legal;
    exp_t             e;
    logic [DEC_W-1:0] vec[2];
    vec[0] = 10'b1000010100;
    vec[1] = 10'd1;
    for (int k = 0; k < 2; k++) begin
      drive(vec[k], 1'b1);
      tick;
      n_checks++;
      if (ov_hi !== 1'b1 || sb.size() == 0) begin
        $display("FAIL multi%0d_valid: got out_valid=%b want 1", k, ov_hi);
      end else begin
        e = sb.pop_front();
        last = e;
        if ({bin_hi, bin_lo, en_hi, em_hi, en_lo, em_lo} !== {e, e.none, e.multi})
          $display("FAIL multi%0d: got bin=%0d/%0d none=%b%b multi=%b%b want bin=%0d/%0d none=%b multi=%b",
                   k, bin_hi, bin_lo, en_hi, en_lo, em_hi, em_lo, e.bin_hi, e.bin_lo, e.none, e.multi);
        else n_pass++;
      end
    end
    n_checks++;
    if (last.bin_hi !== 4'd0 || bin_hi !== 4'd0 || em_hi !== 1'b0)
      $display("FAIL legal_after_multi: got bin=%0d multi=%b want bin=0 multi=0", bin_hi, em_hi);
    else n_pass++;
  endtask

  task automatic test_hold;
    exp_t e;
    drive(10'd8, 1'b1);
    tick;
    n_checks++;
    if (ov_hi !== 1'b1 || sb.size() == 0) begin
      $display("FAIL hold_load_valid: got out_valid=%b want 1", ov_hi);
    end else begin
      e = sb.pop_front();
      last = e;
      if (bin_hi !== 4'd3 || bin_lo !== 4'd3 || {en_hi, em_hi} !== 2'b00)
        $display("FAIL hold_load: got bin=%0d/%0d flags=%b%b want bin=3 flags=00",
                 bin_hi, bin_lo, en_hi, em_hi);
      else n_pass++;
    end
    drive(10'd256, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick;
      n_checks++;
      if (ov_hi !== 1'b0 || ov_lo !== 1'b0 || bin_hi !== 4'd3 || bin_lo !== 4'd3 ||
          {en_hi, em_hi} !== 2'b00)
        $display("FAIL hold%0d: got ov=%b%b bin=%0d/%0d flags=%b%b want ov=00 bin=3 flags=00",
                 c, ov_hi, ov_lo, bin_hi, bin_lo, en_hi, em_hi);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    exp_t             e;
    logic             v, prev_v;
    logic [DEC_W-1:0] d;
    prev_v = 1'b0;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       d = DEC_W'(1) << $urandom_range(0, DEC_W - 1);
        1:       d = DEC_W'($urandom);
        2:       d = '0;
        default: d = (DEC_W'(1) << $urandom_range(0, DEC_W - 1)) | (DEC_W'(1) << $urandom_range(0, DEC_W - 1));
      endcase
      v = (n < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(d, v);
      tick;
      n_checks++;
      if (v) begin
        if (ov_hi !== 1'b1 || ov_lo !== 1'b1 || sb.size() == 0) begin
          $display("FAIL b2b%0d_valid: got out_valid=%b/%b want 1", n, ov_hi, ov_lo);
        end else begin
          e = sb.pop_front();
          last = e;
          if ({bin_hi, bin_lo, en_hi, em_hi, en_lo, em_lo} !== {e, e.none, e.multi})
            $display("FAIL b2b%0d: in=%b got bin=%0d/%0d none=%b%b multi=%b%b want bin=%0d/%0d none=%b multi=%b",
                     n, d, bin_hi, bin_lo, en_hi, en_lo, em_hi, em_lo, e.bin_hi, e.bin_lo, e.none, e.multi);
          else n_pass++;
        end
      end else begin
        if (ov_hi !== 1'b0 || {bin_hi, bin_lo, en_hi, em_hi} !== last)
          $display("FAIL b2b%0d_hold: got ov=%b state=%h want ov=0 state=%h (prev_v=%b)",
                   n, ov_hi, {bin_hi, bin_lo, en_hi, em_hi}, last, prev_v);
        else n_pass++;
      end
      prev_v = v;
    end
    drive('0, 1'b0);
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
    else n_pass++;
  endtask

`ifdef DEC2BIN_ERR_CNT_EN
  task automatic test_err_cnt;
    int exp_cnt;
    exp_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      drive('0, 1'b1);
      tick;
      void'(sb.pop_front());
      exp_cnt = (exp_cnt < ERR_CNT_MAX) ? exp_cnt + 1 : ERR_CNT_MAX;
      n_checks++;
      if (cnt_hi !== 8'(exp_cnt) || cnt_lo !== 8'(exp_cnt))
        $display("FAIL err_cnt%0d: got %0d/%0d want %0d", n, cnt_hi, cnt_lo, exp_cnt);
      else n_pass++;
    end
    err_clr = 1'b1;
    drive('0, 1'b1);
    tick;
    void'(sb.pop_front());
    n_checks++;
    if (cnt_hi !== 8'd0) $display("FAIL err_clr_beats_inc: got %0d want 0", cnt_hi);
    else n_pass++;
    err_clr = 1'b0;
    drive(10'b11, 1'b1);
    tick;
    e_pop: last = sb.pop_front();
    n_checks++;
    if (cnt_hi !== 8'd1) $display("FAIL err_cnt_multi: got %0d want 1", cnt_hi);
    else n_pass++;
    drive('0, 1'b0);
    tick;
  endtask
`endif

  initial begin
`ifdef DEC2BIN_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    rst      = 1'b1;
    in_valid = 1'b0;
    dec_in   = '0;
    test_reset;
    test_walking_one;
    test_zero_then_reset;
    test_multi_then_legal;
    test_hold;
    test_back_to_back;
`ifdef DEC2BIN_ERR_CNT_EN
    test_reset;
    test_err_cnt;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decimal_to_binary_encoder.md
Name: decimal_to_binary_encoder

Overview:
Registered 10-line decimal (one-hot) to 4-bit binary encoder. Asserted input line i yields binary code i: bit 0 gives 0, bit 9 gives 9. Flags illegal codes: no bit set, or more than one bit set. Used wherever a one-hot digit select (keypad row, thermometer tap, digit strobe) must become a compact binary index.

Parameters:
DEC_W, 10, number of decimal input lines; legal range 2..16.
BIN_W, 4, output code width; must satisfy 2**BIN_W >= DEC_W.
PRIO_HIGH, 1, multi-hot resolution: 1 = highest set index wins, 0 = lowest set index wins.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
dec_in  input  DEC_W  decimal one-hot input lines
in_valid  input  1  dec_in sampled this cycle when high
bin_out  output  BIN_W  encoded index
out_valid  output  1  bin_out/flags updated from a sampled input
err_none  output  1  sampled input had no bit set
err_multi  output  1  sampled input had more than one bit set

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high. All outputs are registered.
- Reset (rst high at a clk edge): bin_out=0, out_valid=0, err_none=0, err_multi=0. rst has priority over in_valid in the same cycle.
- Latency: 1 cycle. in_valid high at edge N gives results visible after edge N. out_valid at N+1 equals in_valid at N.
- When in_valid is low, bin_out and the error flags hold their last values and out_valid=0.
- Exactly one bit i set: bin_out=i, err_none=0, err_multi=0.
- Zero input: bin_out=0, err_none=1, err_multi=0. A 0 input is distinguishable from a legal bit-0 input only through err_none.
- Multi-hot input: bin_out is the index of the highest set bit (PRIO_HIGH=1) or the lowest set bit (PRIO_HIGH=0). err_multi=1 and err_none=0.
- Input wider than DEC_W is the driver's problem. Truncated upper bits reach the block as a zero input and therefore raise err_none.
- Combinational path: one-hot check (popcount >1, ==0) and priority encoder, computed in parallel. Register stage only at the outputs.
- Back-to-back in_valid every cycle is supported, with no bubbles.

Optional Feature:
Macro DEC2BIN_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (8 bits), a saturating count of sampled inputs with err_none or err_multi.
  - Cleared by rst; holds at 255.
  - Increments once per erroneous sampled input, in the same cycle the flag registers update.
  - Also adds input err_clr (1 bit), a synchronous clear of err_cnt. rst and err_clr both clear the counter. err_clr beats a simultaneous increment.
- Undefined: no err_cnt or err_clr ports. Behaviour is otherwise identical.

Decomposition:
- Package dec2bin_pkg holds:
  - DEC_W_DEF=10 and BIN_W_DEF=4
  - ERR_CNT_W=8 and ERR_CNT_MAX=255
  - typedef err_kind_e {ERR_NONE_OK, ERR_ZERO, ERR_MULTI}
  - a function clog2-style width check used in an elaboration assertion
- One natural sub-module: onehot_prio_enc, the combinational priority encoder plus zero/multi detection, parameterised on DEC_W, BIN_W and PRIO_HIGH. The top adds the registers and the optional counter.

Test Plan:
1. Walking one: reset, then in_valid=1 with dec_in=1,2,4,...,512 on consecutive cycles. Expect bin_out=0,1,...,9 one cycle later, out_valid=1, both error flags 0.
2. Zero input, then reset: dec_in=0 (the result of a truncated 1024) gives bin_out=0 and err_none=1. Then rst mid-stream clears all outputs on the next edge, even with in_valid high.
3. Multi-hot: dec_in=10'b1000010100 gives bin_out=9 and err_multi=1 with PRIO_HIGH=1. The same input gives bin_out=2 with PRIO_HIGH=0.
4. Hold: apply dec_in=8 with in_valid=1, then in_valid=0 with dec_in=256. Expect bin_out stays 3 and out_valid drops to 0.
5. Error counter (with DEC2BIN_ERR_CNT_EN): apply 300 zero inputs. Expect err_cnt saturates at 255. err_clr asserted together with an erroneous input gives err_cnt=0.
6. Legal after illegal: the cycle after a multi-hot input, dec_in=1. Expect bin_out=0, err_multi=0, err_none=0.
